multi_divid_seq: RTL and testbench
==================================

Name: multi_divid_seq

Overview:
- Sequential, handshaked counterpart of the combinational signed multiply/divide unit, with the same operand, opcode and result semantics.
- Responder side of a valid/ready operation interface: accepts one operation (a, b, signal), iterates one bit per clock, returns registered m, r, error.
- Used where the combinational array is too large or too slow; drop-in result encoding, so existing expected values carry over.

Parameters:
N, 5, operand/result width in bits (signed two's complement), N >= 3

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  initiator presents an operation
in_ready  output  1  block can accept; = (state==IDLE) && !rst
a  input  N  signed operand A (dividend / multiplicand)
b  input  N  signed operand B (divisor / multiplier)
signal  input  2  opcode: 00 divide, 01 multiply, 10/11 reserved
out_valid  output  1  result registers valid
out_ready  input  1  consumer accepts result
m  output  N  divide: quotient; multiply: upper N bits of 2N-bit product
r  output  N  divide: remainder; multiply: lower N bits of product
error  output  1  divide by zero, divide overflow, or reserved opcode

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, out_valid=0, m=0, r=0, error=0, iteration counter=0. Any in-flight operation is aborted and no result is produced. in_ready=0 while rst is high.
- Accept: in_valid && in_ready at an edge captures a, b and signal. Later input changes are ignored until the next accept.
- FSM states: IDLE, CALC, FIX, DONE.
  - IDLE -> CALC on accept for a normal operation.
  - IDLE -> DONE on accept for a reserved opcode or b==0 with signal==00.
  - CALC runs exactly N cycles: a counter runs 0..N-1, one partial-product add or restoring-subtract step per cycle, on operand magnitudes. CALC -> FIX after step N-1.
  - FIX applies the sign correction, loads m/r/error and sets out_valid. FIX -> DONE.
  - DONE holds m, r, error stable while out_valid && !out_ready. On out_valid && out_ready: out_valid=0, state -> IDLE. in_ready rises the following cycle; no accept happens in the same cycle as result retirement.
- Latency: a normal operation has out_valid=1 exactly N+1 cycles after the accept edge (6 for N=5). The short path (zero divisor, reserved opcode) has out_valid=1 one cycle after the accept edge.
- Multiply (01): {m,r} = signed(a)*signed(b) as a 2N-bit two's complement value. m = bits [2N-1:N], r = bits [N-1:0] (r read as signed N-bit). error=0.
- Divide (00): quotient truncated toward zero; remainder takes the sign of the dividend; a = m*b + r and |r| < |b|. error=0.
- Divide by zero (b==0): error=1, m = {1'b0,{N-1{1'b1}}} (max positive), r = {N{1'b1}} (-1).
- Divide overflow (a = -2^(N-1), b = -1): error=1, m = -2^(N-1) (wrapped), r=0.
- Most-negative operands otherwise: magnitudes are held in N+1 bits internally, so multiply of -2^(N-1) by -2^(N-1) is exact (2N-bit result 2^(2N-2)).
- Reserved opcodes (10/11): error=1, m=0, r=0.
- in_valid while busy: ignored (in_ready=0). Operation is neither queued nor corrupted.
- out_ready high before out_valid: no effect.

Test Plan:
- Divide, N=5: (13,2)->m=6,r=1; (10,-3)->m=-3,r=1; (-7,2)->m=-3,r=-1; (-14,-3)->m=4,r=-2. Each has error=0 and out_valid exactly 6 cycles after accept.
- Multiply, N=5: (-6,7)->m=-2,r=-10; (-6,-7)->m=1,r=10; (5,3)->m=0,r=15; (5,-3)->m=-1,r=-15; (0,3) and (5,0)->m=0,r=0.
- Errors: divide (13,0)->error=1,m=15,r=-1, out_valid 1 cycle after accept; divide (-16,-1)->error=1,m=-16,r=0; signal=10 -> error=1,m=0,r=0.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> m/r/error/out_valid stable, in_ready=0. Then pulse out_ready -> out_valid drops next edge, in_ready=1 one cycle later. Toggle a/b/in_valid during CALC -> result unchanged.
- Reset mid-op: assert rst at CALC step 2 of (-6,7) multiply -> next edge out_valid=0, m=r=error=0, in_ready=1 after rst deasserts. A fresh (5,3) multiply then yields m=0,r=15.
- Random: 30 operations with random opcode 00/01 and operands in [-15,15], random out_ready stalls. Compare against a behavioural signed multiply/divide model, including the error cases.

Source files
------------

// File: rtl/multi_divid_seq.sv
// Sequential signed multiply/divide unit behind a valid/ready handshake.
// Each operation iterates one bit per clock on operand magnitudes, then a FIX cycle restores the signs.
module multi_divid_seq #(
    parameter int N = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [1:0]   signal,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] m,
    output logic [N-1:0] r,
    output logic         error
);

    localparam int CW = $clog2(N + 1);
    localparam int W2 = 2 * N;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_next_state;

    // Captured operation attributes
    logic [1:0]    r_op;
    logic          r_sign_a;
    logic          r_sign_b;
    logic          r_ovf;
    logic [CW-1:0] r_cnt;

    // Multiply datapath: shift-and-add on magnitudes
    logic [W2-1:0] r_acc;
    logic [W2-1:0] r_cand;
    logic [N:0]    r_plier;

    // Divide datapath: restoring division on magnitudes
    logic [N-1:0]  r_quo;
    logic [N-1:0]  r_rem;
    logic [N:0]    r_mb;

    // Result registers
    logic [N-1:0]  r_m;
    logic [N-1:0]  r_r;
    logic          r_error;
    logic          r_out_valid;

    logic          w_accept;
    logic          w_short;
    logic          w_last;
    logic [N:0]    w_ext_a;
    logic [N:0]    w_ext_b;
    logic [N:0]    w_mag_a;
    logic [N:0]    w_mag_b;
    logic [N:0]    w_rem_sh;
    logic          w_sub_ok;
    logic [N-1:0]  w_rem_diff;
    logic          w_neg;
    logic [W2-1:0] w_prod;
    logic [N-1:0]  w_quo_s;
    logic [N-1:0]  w_rem_s;

    assign in_ready  = (r_state == IDLE) && !rst;
    assign w_accept  = in_valid && in_ready;

    // Zero divisor and reserved opcodes skip the iteration entirely.
    assign w_short   = signal[1] || ((signal == 2'b00) && (b == '0));
    assign w_last    = (r_cnt == CW'(N - 1));

    // Magnitudes in N+1 bits so that -2^(N-1) is representable.
    assign w_ext_a   = {a[N-1], a};
    assign w_ext_b   = {b[N-1], b};
    assign w_mag_a   = a[N-1] ? -w_ext_a : w_ext_a;
    assign w_mag_b   = b[N-1] ? -w_ext_b : w_ext_b;

    assign w_rem_sh   = {r_rem, r_quo[N-1]};
    assign w_sub_ok   = (w_rem_sh >= r_mb);
    assign w_rem_diff = w_rem_sh[N-1:0] - r_mb[N-1:0];

    assign w_neg     = r_sign_a ^ r_sign_b;
    assign w_prod    = w_neg ? -r_acc : r_acc;
    assign w_quo_s   = w_neg ? -r_quo : r_quo;
    // Remainder follows the dividend's sign.
    assign w_rem_s   = r_sign_a ? -r_rem : r_rem;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        // NOTE: default assignment first so every path drives w_next_state and no latch is inferred.
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next_state = w_short ? DONE : CALC;
                end
            end
            CALC: begin
                if (w_last) begin
                    w_next_state = FIX;
                end
            end
            FIX: begin
                w_next_state = DONE;
            end
            DONE: begin
                if (r_out_valid && out_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values of its peers.
        if (rst) begin
            r_op        <= '0;
            r_sign_a    <= 1'b0;
            r_sign_b    <= 1'b0;
            r_ovf       <= 1'b0;
            r_cnt       <= '0;
            r_acc       <= '0;
            r_cand      <= '0;
            r_plier     <= '0;
            r_quo       <= '0;
            r_rem       <= '0;
            r_mb        <= '0;
            r_m         <= '0;
            r_r         <= '0;
            r_error     <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_op     <= signal;
                        r_sign_a <= a[N-1];
                        r_sign_b <= b[N-1];
                        r_ovf    <= (a == {1'b1, {(N-1){1'b0}}}) && (b == '1);
                        r_cnt    <= '0;
                        r_acc    <= '0;
                        r_cand   <= {{(N-1){1'b0}}, w_mag_a};
                        r_plier  <= w_mag_b;
                        r_quo    <= w_mag_a[N-1:0];
                        r_rem    <= '0;
                        r_mb     <= w_mag_b;
                    end
                end
                CALC: begin
                    r_cnt <= r_cnt + CW'(1);
                    if (r_op[0]) begin
                        if (r_plier[0]) begin
                            r_acc <= r_acc + r_cand;
                        end
                        r_cand  <= r_cand << 1;
                        r_plier <= r_plier >> 1;
                    end else begin
                        r_rem <= w_sub_ok ? w_rem_diff : w_rem_sh[N-1:0];
                        r_quo <= {r_quo[N-2:0], w_sub_ok};
                    end
                end
                FIX: begin
                    if (r_op[0]) begin
                        r_m     <= w_prod[W2-1:N];
                        r_r     <= w_prod[N-1:0];
                        r_error <= 1'b0;
                    end else begin
                        // Overflow quotient wraps to -2^(N-1) naturally; remainder is zero.
                        r_m     <= w_quo_s;
                        r_r     <= w_rem_s;
                        r_error <= r_ovf;
                    end
                    r_out_valid <= 1'b1;
                end
                DONE: begin
                    if (!r_out_valid) begin
                        // Short path: result is a fixed error encoding.
                        if (r_op[1]) begin
                            r_m <= '0;
                            r_r <= '0;
                        end else begin
                            r_m <= {1'b0, {(N-1){1'b1}}};
                            r_r <= '1;
                        end
                        r_error     <= 1'b1;
                        r_out_valid <= 1'b1;
                    end else if (out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign m         = r_m;
    assign r         = r_r;
    assign error     = r_error;

endmodule

// File: tb/tb_multi_divid_seq.sv
// Directed and random bench for multi_divid_seq: scoreboard queue of model results,
// popped and compared when the unit presents each result.
module tb_multi_divid_seq;

    localparam int N = 5;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [1:0]   signal;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] m;
    logic [N-1:0] r;
    logic         error;

    typedef struct {
        logic [N-1:0] m;
        logic [N-1:0] r;
        logic         err;
        int           lat;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    multi_divid_seq #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .signal    (signal),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .m         (m),
        .r         (r),
        .error     (error)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Behavioural reference built on the simulator's signed arithmetic.
    function automatic exp_t model(input logic [1:0] op, input int av, input int bv);
        exp_t             e;
        int               p;
        int               q;
        int               rm;
        logic [2*N-1:0]   pv;
        int               minv;
        minv  = -(1 << (N - 1));
        e.m   = '0;
        e.r   = '0;
        e.err = 1'b0;
        e.lat = N + 1;
        if (op[1]) begin
            e.err = 1'b1;
            e.lat = 1;
        end else if (op == 2'b01) begin
            p   = av * bv;
            pv  = p[2*N-1:0];
            e.m = pv[2*N-1:N];
            e.r = pv[N-1:0];
        end else if (bv == 0) begin
            e.err = 1'b1;
            e.lat = 1;
            q     = (1 << (N - 1)) - 1;
            e.m   = q[N-1:0];
            e.r   = '1;
        end else if (av == minv && bv == -1) begin
            e.err = 1'b1;
            e.m   = av[N-1:0];
        end else begin
            q   = av / bv;
            rm  = av % bv;
            e.m = q[N-1:0];
            e.r = rm[N-1:0];
        end
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic start_op(input logic [1:0] op, input int av, input int bv);
        int w;
        w = 0;
        while (!in_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        check("in_ready_before_accept", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        signal   = op;
        a        = av[N-1:0];
        b        = bv[N-1:0];
        exp_q.push_back(model(op, av, bv));
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic finish_op(input int stall, input bit noise, input bit early);
        exp_t e;
        int   lat;
        int   tmp;
        lat = 0;
        out_ready = early;
        while (!out_valid && lat < 50) begin
            if (noise) begin
                tmp      = int'($urandom);
                a        = tmp[N-1:0];
                b        = tmp[2*N-1:N];
                signal   = tmp[21:20];
                in_valid = tmp[31];
            end
            @(negedge clk);
            lat++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        if (exp_q.size() == 0) begin
            check("scoreboard_nonempty", 32'(exp_q.size()), 32'd1);
            return;
        end
        e = exp_q.pop_front();
        check("latency", 32'(lat), 32'(e.lat));
        check("out_valid", 32'(out_valid), 32'd1);
        check("m", 32'(m), 32'(e.m));
        check("r", 32'(r), 32'(e.r));
        check("error", 32'(error), 32'(e.err));
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_m", 32'(m), 32'(e.m));
            check("hold_r", 32'(r), 32'(e.r));
            check("hold_error", 32'(error), 32'(e.err));
            check("hold_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("retire_valid", 32'(out_valid), 32'd0);
        check("retire_in_ready", 32'(in_ready), 32'd1);
    endtask

    task automatic do_op(input logic [1:0] op, input int av, input int bv,
                         input int stall, input bit noise, input bit early);
        start_op(op, av, bv);
        finish_op(stall, noise, early);
    endtask

    initial begin
        int op_i;
        int av;
        int bv;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        signal    = 2'b00;
        repeat (2) @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_m", 32'(m), 32'd0);
        check("rst_r", 32'(r), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);

        // Divide
        do_op(2'b00,  13,  2, 0, 0, 0);
        do_op(2'b00,  10, -3, 0, 0, 0);
        do_op(2'b00,  -7,  2, 1, 0, 0);
        do_op(2'b00, -14, -3, 0, 0, 1);

        // Multiply
        do_op(2'b01, -6,  7, 0, 0, 0);
        do_op(2'b01, -6, -7, 0, 0, 0);
        do_op(2'b01,  5,  3, 0, 0, 0);
        do_op(2'b01,  5, -3, 0, 0, 0);
        do_op(2'b01,  0,  3, 0, 0, 0);
        do_op(2'b01,  5,  0, 0, 0, 0);
        do_op(2'b01, -16, -16, 0, 0, 0);
        do_op(2'b01, -16,  15, 0, 0, 0);

        // Error and boundary cases
        do_op(2'b00,  13,  0, 0, 0, 0);
        do_op(2'b00, -16, -1, 0, 0, 0);
        do_op(2'b10,   7,  3, 0, 0, 0);
        do_op(2'b11,  -2,  0, 0, 0, 0);
        do_op(2'b00, -16,  1, 0, 0, 0);
        do_op(2'b00,  15, -16, 0, 0, 0);

        // Backpressure, then input noise while busy
        do_op(2'b01,   5,  3, 10, 0, 0);
        do_op(2'b00, -14, -3, 2, 1, 0);
        do_op(2'b01,  -6,  7, 0, 1, 0);

        // Reset during CALC step 2; the aborted result must never appear
        start_op(2'b01, -6, 7);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_m", 32'(m), 32'd0);
        check("abort_r", 32'(r), 32'd0);
        check("abort_error", 32'(error), 32'd0);
        check("abort_in_ready_in_rst", 32'(in_ready), 32'd0);
        rst = 1'b0;
        #1;
        check("abort_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        do_op(2'b01, 5, 3, 0, 0, 0);

        // Random operations with random stalls
        for (int i = 0; i < 30; i++) begin
            op_i = int'($urandom_range(0, 1));
            av   = int'($urandom_range(0, 30)) - 15;
            bv   = int'($urandom_range(0, 30)) - 15;
            do_op(op_i[1:0], av, bv, int'($urandom_range(0, 3)),
                  1'b0, ($urandom_range(0, 1) == 1));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
